// File: rtl/decoder_nxm_scan.sv
// Registered N-to-M one-hot decoder with a direct (valid/ready) mode and a
// self-sweeping scan mode that holds each line for a programmable dwell time.
module decoder_nxm_scan #(
  parameter int SEL_W   = 5,
  parameter int OUT_W   = 32,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel_in,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               start,
  input  logic               stop,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               busy,
  output logic               wrap,
  output logic               err
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(OUT_W - 1);

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   cur_sel_reg, cur_sel_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic [DWELL_W-1:0] dwell_q_reg, dwell_q_next;
  logic               active_reg, active_next;  // a direct line is latched and should be shown
  logic [OUT_W-1:0]   out_reg, out_next;
  logic               out_valid_reg, out_valid_next;
  logic               wrap_reg, wrap_next;
  logic               err_reg, err_next;
  logic               in_range;

  assign sel_ready = (state_reg == IDLE) && !mode && en;
  assign in_range  = ({1'b0, sel_in} < (SEL_W + 1)'(OUT_W));

  always_comb begin
    state_next   = state_reg;
    cur_sel_next = cur_sel_reg;
    cnt_next     = cnt_reg;
    dwell_q_next = dwell_q_reg;
    active_next  = active_reg;
    wrap_next    = 1'b0;
    err_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (stop) begin
          active_next = 1'b0;
        end else if (en && mode && start) begin
          state_next   = SCAN;
          cur_sel_next = '0;
          cnt_next     = dwell;
          dwell_q_next = dwell;
          active_next  = 1'b0;
        end else if (sel_ready && sel_valid) begin
          if (in_range) begin
            active_next  = 1'b1;
            cur_sel_next = sel_in;
          end else begin
            active_next = 1'b0;
            err_next    = 1'b1;
          end
        end
      end
      SCAN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (en) begin
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
          end else begin
            cnt_next     = dwell_q_reg;
            cur_sel_next = (cur_sel_reg == LAST_SEL) ? '0 : cur_sel_reg + 1'b1;
            wrap_next    = (cur_sel_reg == LAST_SEL);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // The output always mirrors the line the next state points at, blanked while disabled.
    out_valid_next = en && ((state_next == SCAN) || active_next);
    out_next       = out_valid_next ? (OUT_W'(1) << cur_sel_next) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cur_sel_reg   <= '0;
      cnt_reg       <= '0;
      dwell_q_reg   <= '0;
      active_reg    <= 1'b0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      wrap_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_sel_reg   <= cur_sel_next;
      cnt_reg       <= cnt_next;
      dwell_q_reg   <= dwell_q_next;
      active_reg    <= active_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      wrap_reg      <= wrap_next;
      err_reg       <= err_next;
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign cur_sel   = cur_sel_reg;
  assign busy      = (state_reg == SCAN);
  assign wrap      = wrap_reg;
  assign err       = err_reg;

endmodule
